// File: rtl/rom_cache_pkg.sv
// rom_cache_pkg: shared line geometry, FSM states and word extraction for the ROM line cache
package rom_cache_pkg;

    localparam int LINE_BYTES     = 8;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_LSB       = $clog2(LINE_BYTES);
    localparam int OFF_W          = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    function automatic logic [15:0] word_sel(input logic [63:0] line, input logic [OFF_W-1:0] off);
        return line[{off, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/rom_cache_ram.sv
// rom_cache_ram: simple dual-port RAM with a registered read port, shaped for block-RAM inference
module rom_cache_ram #(
    parameter int W  = 64,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rd_q;

    assign rdata = rd_q;

    // Write port and registered read port; no reset so the array maps onto RAM blocks
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_q <= mem[raddr];
    end

endmodule

// File: rtl/rom_line_cache.sv
// rom_line_cache: read-only direct-mapped 64-bit line cache between the core ROM port and ddram
module rom_line_cache
    import rom_cache_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int IDX_W  = 6
) (
    input  logic              MCLK,
    input  logic              RESET_N,
    input  logic              inval,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [15:0]       cpu_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [63:0]       mem_data,
    output logic              hit_o
);

    localparam int TAG_W = ADDR_W - LINE_LSB - IDX_W;
    localparam int LINES = 2**IDX_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:1]   addr_q, addr_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic [15:0]         cpu_data_q, cpu_data_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_req_q, mem_req_d;
    logic                hit_q, hit_d;
    logic                inv_q, inv_d;
    logic                we;
    logic                hit;
    logic [63:0]         data_rd;
    logic [TAG_W-1:0]    tag_rd;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic [OFF_W-1:0]    off_q;
    logic                unused;

    assign idx_q    = addr_q[IDX_W+LINE_LSB-1:LINE_LSB];
    assign tag_q    = addr_q[ADDR_W-1:IDX_W+LINE_LSB];
    assign off_q    = addr_q[LINE_LSB-1:1];
    assign unused   = cpu_addr[0];
    assign cpu_ack  = cpu_ack_q;
    assign cpu_data = cpu_data_q;
    assign mem_addr = mem_addr_q;
    assign mem_req  = mem_req_q;
    assign hit_o    = hit_q;

    rom_cache_ram #(.W(64), .AW(IDX_W)) u_data (
        .clk(MCLK), .we(we), .waddr(idx_q), .wdata(mem_data),
        .re(state_q == IDLE), .raddr(cpu_addr[IDX_W+LINE_LSB-1:LINE_LSB]), .rdata(data_rd)
    );

    rom_cache_ram #(.W(TAG_W), .AW(IDX_W)) u_tag (
        .clk(MCLK), .we(we), .waddr(idx_q), .wdata(tag_q),
        .re(state_q == IDLE), .raddr(cpu_addr[IDX_W+LINE_LSB-1:LINE_LSB]), .rdata(tag_rd)
    );

    // Lookup/fill sequencing; outside a fill mem_req follows mem_ack so stale ddram acks cannot desync
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        valid_d    = inval ? '0 : valid_q;
        cpu_ack_d  = cpu_ack_q;
        cpu_data_d = cpu_data_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_ack;
        hit_d      = 1'b0;
        inv_d      = inv_q | inval;
        we         = 1'b0;
        hit        = valid_q[idx_q] && (tag_rd == tag_q) && !inval;
        case (state_q)
            IDLE: begin
                if (cpu_req != cpu_ack_q) begin
                    addr_d  = cpu_addr[ADDR_W-1:1];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_data_d = word_sel(data_rd, off_q);
                    cpu_ack_d  = cpu_req;
                    hit_d      = 1'b1;
                    state_d    = IDLE;
                end else begin
                    mem_addr_d = {addr_q[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
                    mem_req_d  = ~mem_ack;
                    inv_d      = inval;
                    state_d    = FILL;
                end
            end
            FILL: begin
                mem_req_d = mem_req_q;
                if (mem_ack == mem_req_q) begin
                    we         = 1'b1;
                    cpu_data_d = word_sel(mem_data, off_q);
                    cpu_ack_d  = cpu_req;
                    state_d    = IDLE;
                    if (!(inv_q || inval)) valid_d[idx_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            valid_q    <= '0;
            cpu_ack_q  <= 1'b0;
            cpu_data_q <= '0;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            hit_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            cpu_ack_q  <= cpu_ack_d;
            cpu_data_q <= cpu_data_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            hit_q      <= hit_d;
            inv_q      <= inv_d;
        end
    end

endmodule
